// File: rtl/id_alu_issue_pkg.sv
// Shared constants and types for the decode/issue stage that feeds the ALU.
package id_alu_issue_pkg;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam int          ALU_CTRL_W = 12;

    // One-hot bit positions inside alu_control
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Where operand 2 comes from
    typedef enum logic [1:0] {
        SRC2_RT   = 2'd0,
        SRC2_ZIMM = 2'd1,
        SRC2_SIMM = 2'd2
    } src2_sel_e;

    // Decoder output: everything the top needs besides register data
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_control;
        logic                  src1_is_sa;
        src2_sel_e             src2_sel;
        logic                  reads_rs;
        logic                  reads_rt;
        logic                  we;
        logic [4:0]            waddr;
    } dec_t;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic                  valid;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [31:0]           src1;
        logic [31:0]           src2;
        logic                  we;
        logic [4:0]            waddr;
    } idex_t;

    // Bypass selection for one source register; EX wins over MEM, $0 is never bypassed
    function automatic logic [31:0] fwd_value(
        input logic [4:0]  addr,
        input logic [31:0] rf_data,
        input logic        ex_we,
        input logic        ex_load,
        input logic [4:0]  ex_waddr,
        input logic [31:0] ex_wdata,
        input logic        mem_we,
        input logic [4:0]  mem_waddr,
        input logic [31:0] mem_wdata
    );
        if (addr == 5'd0)
            return ZERO_WORD;
        else if (ex_we && !ex_load && (ex_waddr == addr))
            return ex_wdata;
        else if (mem_we && (mem_waddr == addr))
            return mem_wdata;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/id_alu_issue_if.sv
// ID/EX issue bus: the decode stage (master) presents an entry, EX (slave) grants allowin.
interface id_alu_issue_if;
    import id_alu_issue_pkg::*;

    logic                  ex_allowin;
    logic                  ex_valid;
    logic [ALU_CTRL_W-1:0] ex_alu_control;
    logic [31:0]           ex_alu_src1;
    logic [31:0]           ex_alu_src2;
    logic                  ex_we;
    logic [4:0]            ex_waddr;

    modport master (
        input  ex_allowin,
        output ex_valid, ex_alu_control, ex_alu_src1, ex_alu_src2, ex_we, ex_waddr
    );

    modport slave (
        output ex_allowin,
        input  ex_valid, ex_alu_control, ex_alu_src1, ex_alu_src2, ex_we, ex_waddr
    );
endinterface

// File: rtl/id_alu_issue_dec.sv
// Combinational MIPS decoder: opcode/funct -> one-hot alu_control, operand selects,
// which sources are really read, and the destination register.
module id_alu_issue_dec
    import id_alu_issue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;

    assign op = inst[31:26];
    assign fn = inst[5:0];
    assign rt = inst[20:16];
    assign rd = inst[15:11];

    // Decode the instruction word into control fields
    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        dec = '0;
        case (op)
            OP_SPECIAL: begin
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
                dec.we       = 1'b1;
                dec.waddr    = rd;
                dec.src2_sel = SRC2_RT;
                case (fn)
                    FN_ADDU: dec.alu_control[ALU_ADD]  = 1'b1;
                    FN_SUBU: dec.alu_control[ALU_SUB]  = 1'b1;
                    FN_SLT:  dec.alu_control[ALU_SLT]  = 1'b1;
                    FN_SLTU: dec.alu_control[ALU_SLTU] = 1'b1;
                    FN_AND:  dec.alu_control[ALU_AND]  = 1'b1;
                    FN_NOR:  dec.alu_control[ALU_NOR]  = 1'b1;
                    FN_OR:   dec.alu_control[ALU_OR]   = 1'b1;
                    FN_XOR:  dec.alu_control[ALU_XOR]  = 1'b1;
                    FN_SLLV: dec.alu_control[ALU_SLL]  = 1'b1;
                    FN_SRLV: dec.alu_control[ALU_SRL]  = 1'b1;
                    FN_SRAV: dec.alu_control[ALU_SRA]  = 1'b1;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        // Immediate shifts take the amount from sa and never read rs
                        dec.src1_is_sa = 1'b1;
                        dec.reads_rs   = 1'b0;
                        dec.alu_control[ALU_SLL] = (fn == FN_SLL);
                        dec.alu_control[ALU_SRL] = (fn == FN_SRL);
                        dec.alu_control[ALU_SRA] = (fn == FN_SRA);
                    end
                    default: dec = '0;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                dec.reads_rs = 1'b1;
                dec.we       = 1'b1;
                dec.waddr    = rt;
                dec.src2_sel = SRC2_SIMM;
                dec.alu_control[ALU_ADD]  = (op == OP_ADDIU) || (op == OP_LW);
                dec.alu_control[ALU_SLT]  = (op == OP_SLTI);
                dec.alu_control[ALU_SLTU] = (op == OP_SLTIU);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec.reads_rs = 1'b1;
                dec.we       = 1'b1;
                dec.waddr    = rt;
                dec.src2_sel = SRC2_ZIMM;
                dec.alu_control[ALU_AND] = (op == OP_ANDI);
                dec.alu_control[ALU_OR]  = (op == OP_ORI);
                dec.alu_control[ALU_XOR] = (op == OP_XORI);
            end
            OP_LUI: begin
                dec.we       = 1'b1;
                dec.waddr    = rt;
                dec.src2_sel = SRC2_ZIMM;
                dec.alu_control[ALU_LUI] = 1'b1;
            end
            OP_SW: begin
                // Store computes an address; rt is the store data, nothing is written back
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
                dec.src2_sel = SRC2_SIMM;
                dec.alu_control[ALU_ADD] = 1'b1;
            end
            default: dec = '0;
        endcase
        // Writes to $0 are discarded at the source
        if (dec.waddr == 5'd0)
            dec.we = 1'b0;
    end

endmodule

// File: rtl/id_alu_issue.sv
// Decode stage in front of the ALU: operand bypass from EX/MEM, load-use stall,
// and the ID/EX pipeline register presented on the issue bus.
module id_alu_issue
    import id_alu_issue_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          if_valid,
    input  logic [31:0]   if_inst,
    output logic          id_ready,
    input  logic          flush,
    output logic [4:0]    rs_addr,
    output logic [4:0]    rt_addr,
    input  logic [31:0]   rs_rdata,
    input  logic [31:0]   rt_rdata,
    input  logic          ex_fwd_we,
    input  logic          ex_fwd_load,
    input  logic [4:0]    ex_fwd_waddr,
    input  logic [31:0]   ex_fwd_wdata,
    input  logic          mem_fwd_we,
    input  logic [4:0]    mem_fwd_waddr,
    input  logic [31:0]   mem_fwd_wdata,
    id_alu_issue_if.master ex_bus
);

    dec_t        dec;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall;
    idex_t       idex_d;
    idex_t       idex_q;

    assign rs_addr = if_inst[25:21];
    assign rt_addr = if_inst[20:16];

    id_alu_issue_dec u_dec (
        .inst (if_inst),
        .dec  (dec)
    );

    // Bypassed register values and ALU operand selection
    always_comb begin
        rs_val = fwd_value(rs_addr, rs_rdata, ex_fwd_we, ex_fwd_load, ex_fwd_waddr,
                           ex_fwd_wdata, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);
        rt_val = fwd_value(rt_addr, rt_rdata, ex_fwd_we, ex_fwd_load, ex_fwd_waddr,
                           ex_fwd_wdata, mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata);
        src1 = dec.src1_is_sa ? {27'b0, if_inst[10:6]} : rs_val;
        case (dec.src2_sel)
            SRC2_ZIMM: src2 = {16'b0, if_inst[15:0]};
            SRC2_SIMM: src2 = {{16{if_inst[15]}}, if_inst[15:0]};
            default:   src2 = rt_val;
        endcase
    end

    // Load-use hazard: only sources the instruction really reads can stall it
    always_comb begin
        stall = if_valid && ex_fwd_load && ex_fwd_we && (ex_fwd_waddr != 5'd0) &&
                ((dec.reads_rs && (rs_addr == ex_fwd_waddr)) ||
                 (dec.reads_rt && (rt_addr == ex_fwd_waddr)));
        id_ready = flush || (!stall && ex_bus.ex_allowin);
    end

    // Next-state of the ID/EX register: flush kills, allowin loads, otherwise hold
    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d.valid = 1'b0;
        end else if (ex_bus.ex_allowin) begin
            idex_d.valid       = if_valid && !stall;
            idex_d.alu_control = dec.alu_control;
            idex_d.src1        = src1;
            idex_d.src2        = src2;
            idex_d.we          = dec.we;
            idex_d.waddr       = dec.waddr;
        end
    end

    // ID/EX register, cleared asynchronously so nothing survives a reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idex_q <= '0;
        end else begin
            // NOTE: non-blocking so the register samples pre-edge values regardless of block order.
            idex_q <= idex_d;
        end
    end

    assign ex_bus.ex_valid       = idex_q.valid;
    assign ex_bus.ex_alu_control = idex_q.alu_control;
    assign ex_bus.ex_alu_src1    = idex_q.src1;
    assign ex_bus.ex_alu_src2    = idex_q.src2;
    assign ex_bus.ex_we          = idex_q.we;
    assign ex_bus.ex_waddr       = idex_q.waddr;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue: decode, shifts, bypass, load-use, backpressure, flush, reset.
module tb_id_alu_issue;

    logic        clk;
    logic        resetn;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_rdata;
    logic [31:0] rt_rdata;
    logic        ex_fwd_we;
    logic        ex_fwd_load;
    logic [4:0]  ex_fwd_waddr;
    logic [31:0] ex_fwd_wdata;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_waddr;
    logic [31:0] mem_fwd_wdata;
    logic [31:0] rf [32];

    int n_cmp;
    int n_err;

    id_alu_issue_if ex_if ();

    id_alu_issue dut (
        .clk           (clk),
        .resetn        (resetn),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .id_ready      (id_ready),
        .flush         (flush),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_rdata      (rs_rdata),
        .rt_rdata      (rt_rdata),
        .ex_fwd_we     (ex_fwd_we),
        .ex_fwd_load   (ex_fwd_load),
        .ex_fwd_waddr  (ex_fwd_waddr),
        .ex_fwd_wdata  (ex_fwd_wdata),
        .mem_fwd_we    (mem_fwd_we),
        .mem_fwd_waddr (mem_fwd_waddr),
        .mem_fwd_wdata (mem_fwd_wdata),
        .ex_bus        (ex_if)
    );

    // Register file model
    assign rs_rdata = rf[rs_addr];
    assign rt_rdata = rf[rt_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid      = 1'b0;
        if_inst       = 32'h0;
        flush         = 1'b0;
        ex_fwd_we     = 1'b0;
        ex_fwd_load   = 1'b0;
        ex_fwd_waddr  = 5'd0;
        ex_fwd_wdata  = 32'h0;
        mem_fwd_we    = 1'b0;
        mem_fwd_waddr = 5'd0;
        mem_fwd_wdata = 32'h0;
        ex_if.ex_allowin = 1'b1;
    endtask

    task automatic issue(input logic [31:0] inst);
        if_valid = 1'b1;
        if_inst  = inst;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        n_cmp++;
        if ({ex_if.ex_valid, ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2,
             ex_if.ex_we, ex_if.ex_waddr} !== 83'h0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b ctrl=%h src1=%h src2=%h, want all zero",
                     ex_if.ex_valid, ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        resetn = 1'b1;
        issue(i_type(6'h09, 5'd1, 5'd2, 16'hFFFF));
        n_cmp++;
        if (ex_if.ex_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_valid: got %b want 1", ex_if.ex_valid);
        end
        #3 resetn = 1'b0;
        #1;
        n_cmp++;
        if (ex_if.ex_valid !== 1'b0 || ex_if.ex_alu_control !== 12'h000) begin
            n_err++;
            $display("FAIL reset_async: got valid=%b ctrl=%h want 0/000",
                     ex_if.ex_valid, ex_if.ex_alu_control);
        end
        tick();
        n_cmp++;
        if (ex_if.ex_valid !== 1'b0 || ex_if.ex_alu_control !== 12'h000) begin
            n_err++;
            $display("FAIL reset_hold: got valid=%b ctrl=%h want 0/000",
                     ex_if.ex_valid, ex_if.ex_alu_control);
        end
        resetn = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_decode();
        issue(i_type(6'h09, 5'd1, 5'd2, 16'hFFFF));   // ADDIU $2,$1,-1
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h800 || ex_if.ex_alu_src1 !== 32'd5 ||
            ex_if.ex_alu_src2 !== 32'hFFFF_FFFF || ex_if.ex_waddr !== 5'd2 ||
            ex_if.ex_we !== 1'b1 || ex_if.ex_valid !== 1'b1) begin
            n_err++;
            $display("FAIL addiu: got ctrl=%h s1=%h s2=%h wa=%0d we=%b v=%b want 800/5/ffffffff/2/1/1",
                     ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2,
                     ex_if.ex_waddr, ex_if.ex_we, ex_if.ex_valid);
        end
        issue(i_type(6'h0D, 5'd0, 5'd3, 16'h8000));   // ORI $3,$0,0x8000
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h020 || ex_if.ex_alu_src1 !== 32'd0 ||
            ex_if.ex_alu_src2 !== 32'h0000_8000 || ex_if.ex_waddr !== 5'd3) begin
            n_err++;
            $display("FAIL ori: got ctrl=%h s1=%h s2=%h wa=%0d want 020/0/00008000/3",
                     ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2, ex_if.ex_waddr);
        end
        issue(i_type(6'h0F, 5'd0, 5'd4, 16'h1234));   // LUI $4,0x1234
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h001 || ex_if.ex_alu_src2 !== 32'h0000_1234 ||
            ex_if.ex_waddr !== 5'd4 || ex_if.ex_we !== 1'b1) begin
            n_err++;
            $display("FAIL lui: got ctrl=%h s2=%h wa=%0d we=%b want 001/00001234/4/1",
                     ex_if.ex_alu_control, ex_if.ex_alu_src2, ex_if.ex_waddr, ex_if.ex_we);
        end
        issue(i_type(6'h2B, 5'd1, 5'd3, 16'h0008));   // SW $3,8($1)
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h800 || ex_if.ex_we !== 1'b0 ||
            ex_if.ex_alu_src1 !== 32'd5 || ex_if.ex_alu_src2 !== 32'd8) begin
            n_err++;
            $display("FAIL sw: got ctrl=%h we=%b s1=%h s2=%h want 800/0/5/8",
                     ex_if.ex_alu_control, ex_if.ex_we, ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        issue(i_type(6'h3F, 5'd1, 5'd2, 16'h0000));   // unsupported opcode
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h000 || ex_if.ex_we !== 1'b0) begin
            n_err++;
            $display("FAIL unsupported: got ctrl=%h we=%b want 000/0",
                     ex_if.ex_alu_control, ex_if.ex_we);
        end
        issue(r_type(5'd1, 5'd3, 5'd0, 5'd0, 6'h2A)); // SLT $0,$1,$3
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h200 || ex_if.ex_we !== 1'b0) begin
            n_err++;
            $display("FAIL dest_zero: got ctrl=%h we=%b want 200/0",
                     ex_if.ex_alu_control, ex_if.ex_we);
        end
        idle();
        tick();
    endtask

    task automatic test_shifts();
        issue(r_type(5'd0, 5'd6, 5'd5, 5'd4, 6'h00)); // SLL $5,$6,4
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h008 || ex_if.ex_alu_src1 !== 32'd4 ||
            ex_if.ex_alu_src2 !== 32'h0000_00F0 || ex_if.ex_waddr !== 5'd5) begin
            n_err++;
            $display("FAIL sll: got ctrl=%h s1=%h s2=%h wa=%0d want 008/4/f0/5",
                     ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2, ex_if.ex_waddr);
        end
        issue(r_type(5'd7, 5'd6, 5'd5, 5'd0, 6'h07)); // SRAV $5,$6,$7
        n_cmp++;
        if (ex_if.ex_alu_control !== 12'h002 || ex_if.ex_alu_src1 !== 32'd3 ||
            ex_if.ex_alu_src2 !== 32'h0000_00F0) begin
            n_err++;
            $display("FAIL srav: got ctrl=%h s1=%h s2=%h want 002/3/f0",
                     ex_if.ex_alu_control, ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        idle();
        tick();
    endtask

    task automatic test_forward();
        ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'h0000_000A;
        mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'h0000_000B;
        issue(r_type(5'd1, 5'd1, 5'd2, 5'd0, 6'h21)); // ADDU $2,$1,$1
        n_cmp++;
        if (ex_if.ex_alu_src1 !== 32'hA || ex_if.ex_alu_src2 !== 32'hA) begin
            n_err++;
            $display("FAIL fwd_ex_prio: got s1=%h s2=%h want a/a",
                     ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        ex_fwd_we = 1'b0;
        issue(r_type(5'd1, 5'd3, 5'd2, 5'd0, 6'h21)); // ADDU $2,$1,$3
        n_cmp++;
        if (ex_if.ex_alu_src1 !== 32'hB || ex_if.ex_alu_src2 !== 32'h33) begin
            n_err++;
            $display("FAIL fwd_mem: got s1=%h s2=%h want b/33",
                     ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        ex_fwd_we = 1'b1; ex_fwd_waddr = 5'd0;
        mem_fwd_waddr = 5'd0;
        issue(r_type(5'd0, 5'd0, 5'd2, 5'd0, 6'h21)); // ADDU $2,$0,$0
        n_cmp++;
        if (ex_if.ex_alu_src1 !== 32'h0 || ex_if.ex_alu_src2 !== 32'h0) begin
            n_err++;
            $display("FAIL fwd_zero: got s1=%h s2=%h want 0/0",
                     ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        ex_fwd_we = 1'b1; ex_fwd_load = 1'b1; ex_fwd_waddr = 5'd1; ex_fwd_wdata = 32'hDEAD;
        if_valid = 1'b1;
        if_inst  = r_type(5'd1, 5'd3, 5'd2, 5'd0, 6'h21); // ADDU $2,$1,$3
        #1;
        n_cmp++;
        if (id_ready !== 1'b0) begin
            n_err++;
            $display("FAIL lu_ready: got %b want 0", id_ready);
        end
        tick();
        n_cmp++;
        if (ex_if.ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lu_bubble: got valid=%b want 0", ex_if.ex_valid);
        end
        ex_fwd_we = 1'b0; ex_fwd_load = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_waddr = 5'd1; mem_fwd_wdata = 32'h77;
        #1;
        n_cmp++;
        if (id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lu_release: got %b want 1", id_ready);
        end
        tick();
        n_cmp++;
        if (ex_if.ex_valid !== 1'b1 || ex_if.ex_alu_src1 !== 32'h77 ||
            ex_if.ex_alu_src2 !== 32'h33) begin
            n_err++;
            $display("FAIL lu_mem_data: got v=%b s1=%h s2=%h want 1/77/33",
                     ex_if.ex_valid, ex_if.ex_alu_src1, ex_if.ex_alu_src2);
        end
        // Load target only in the unused rs field of SLL: no stall
        idle();
        ex_fwd_we = 1'b1; ex_fwd_load = 1'b1; ex_fwd_waddr = 5'd1;
        if_valid = 1'b1;
        if_inst  = r_type(5'd1, 5'd6, 5'd5, 5'd4, 6'h00);
        #1;
        n_cmp++;
        if (id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lu_unused_src: got ready=%b want 1", id_ready);
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure_flush();
        issue(i_type(6'h09, 5'd1, 5'd2, 16'hFFFF));   // ADDIU $2,$1,-1
        ex_if.ex_allowin = 1'b0;
        if_inst = i_type(6'h0D, 5'd0, 5'd3, 16'h8000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (ex_if.ex_valid !== 1'b1 || ex_if.ex_alu_control !== 12'h800 ||
                ex_if.ex_alu_src2 !== 32'hFFFF_FFFF || id_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_frozen[%0d]: got v=%b ctrl=%h s2=%h rdy=%b want 1/800/ffffffff/0",
                         i, ex_if.ex_valid, ex_if.ex_alu_control, ex_if.ex_alu_src2, id_ready);
            end
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready: got %b want 1", id_ready);
        end
        tick();
        n_cmp++;
        if (ex_if.ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_kill: got valid=%b want 0", ex_if.ex_valid);
        end
        // Flush together with a load-use stall: flush wins
        ex_if.ex_allowin = 1'b1;
        ex_fwd_we = 1'b1; ex_fwd_load = 1'b1; ex_fwd_waddr = 5'd1;
        if_inst = r_type(5'd1, 5'd3, 5'd2, 5'd0, 6'h21);
        #1;
        n_cmp++;
        if (id_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_stall_ready: got %b want 1", id_ready);
        end
        tick();
        n_cmp++;
        if (ex_if.ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stall_kill: got valid=%b want 0", ex_if.ex_valid);
        end
        idle();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'd5;
        rf[3] = 32'h33;
        rf[6] = 32'hF0;
        rf[7] = 32'd3;
        test_reset();
        test_decode();
        test_shifts();
        test_forward();
        test_load_use();
        test_backpressure_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
